// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-requester memory port arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    localparam int NUM_REQ     = 4;
    localparam int SEL_W       = 2;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side bundle of the memory port arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    // Handshake: a requester holds req (and its addr/wdata/we) until it sees its
    // done bit; the memory completes the granted transaction by asserting
    // mem_ready for one edge while mem_valid is high, with mem_rdata valid then.
    logic [3:0]        req;
    logic [3:0]        we;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] addr3;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic [DATA_W-1:0] wdata3;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic              mem_valid;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        done;
    logic              err;

    modport slave (
        input  req, we, addr0, addr1, addr2, addr3,
        input  wdata0, wdata1, wdata2, wdata3,
        input  mem_ready, mem_rdata,
        output gnt, sel, mem_valid, mem_we, mem_addr, mem_wdata,
        output rdata, done, err
    );

    modport master (
        output req, we, addr0, addr1, addr2, addr3,
        output wdata0, wdata1, wdata2, wdata3,
        output mem_ready, mem_rdata,
        input  gnt, sel, mem_valid, mem_we, mem_addr, mem_wdata,
        input  rdata, done, err
    );

endinterface

// File: rtl/mux4_32.sv
// 4:1 word mux used in front of the data-memory port.
module mux4_32 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: the first eligible index after ptr wins,
// wrapping around so that ptr itself has the lowest priority.
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest eligible one sticks.
    always_comb begin
        any  = |eligible;
        idx  = '0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (eligible[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the 32-bit data-memory port among four requesters.
// MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts with err after TIMEOUT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic                Clk,
    input  logic                Reset_n,
    mem_port_arbiter_if.slave   bus,
    output arb_state_t          dbg_state
);

    arb_state_t          state;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    sel_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                mem_valid_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [NUM_REQ-1:0]  eligible;
    logic                pick_any;
    logic [SEL_W-1:0]    pick_idx;

    // A requester that is seeing its done pulse is not eligible, so it can drop req cleanly.
    assign eligible = bus.req & ~done_q;

    rr_pick4 u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    mux4_32 #(.W(DATA_W)) u_addr_mux (
        .sel (sel_q),
        .d0  (bus.addr0),
        .d1  (bus.addr1),
        .d2  (bus.addr2),
        .d3  (bus.addr3),
        .y   (bus.mem_addr)
    );

    mux4_32 #(.W(DATA_W)) u_wdata_mux (
        .sel (sel_q),
        .d0  (bus.wdata0),
        .d1  (bus.wdata1),
        .d2  (bus.wdata2),
        .d3  (bus.wdata3),
        .y   (bus.mem_wdata)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] busy_cnt;
    logic             err_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            sel_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            busy_cnt    <= '0;
            err_q       <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state       <= BUSY;
                        gnt_q       <= idx_to_onehot(pick_idx);
                        sel_q       <= pick_idx;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= bus.we[pick_idx];
                        busy_cnt    <= '0;
                    end
                end
                BUSY: begin
                    // busy_cnt holds (BUSY cycle number - 1); ready wins over expiry.
                    if (bus.mem_ready) begin
                        if (!mem_we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        done_q      <= gnt_q;
                        ptr         <= sel_q;
                        state       <= IDLE;
                        gnt_q       <= '0;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                    end else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
                        done_q      <= gnt_q;
                        err_q       <= 1'b1;
                        ptr         <= sel_q;
                        state       <= IDLE;
                        gnt_q       <= '0;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.err = err_q;
`else
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            sel_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state       <= BUSY;
                        gnt_q       <= idx_to_onehot(pick_idx);
                        sel_q       <= pick_idx;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= bus.we[pick_idx];
                    end
                end
                BUSY: begin
                    // Writes leave the captured read data untouched.
                    if (bus.mem_ready) begin
                        if (!mem_we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        done_q      <= gnt_q;
                        ptr         <= sel_q;
                        state       <= IDLE;
                        gnt_q       <= '0;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, read, fairness, write, priority,
// reset during a transaction and the BUSY watchdog (MEM_ARB_TIMEOUT_EN).
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    mem_arb_pkg::arb_state_t dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    mem_port_arbiter_if #(.DATA_W(32)) bus ();

    mem_port_arbiter #(.DATA_W(32)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req       = 4'b0000;
        bus.we        = 4'b0000;
        bus.addr0     = '0;
        bus.addr1     = '0;
        bus.addr2     = '0;
        bus.addr3     = '0;
        bus.wdata0    = '0;
        bus.wdata1    = '0;
        bus.wdata2    = '0;
        bus.wdata3    = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", bus.sel); end
        checks++; if (bus.mem_valid !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem: got valid=%b we=%b expected 0 0", bus.mem_valid, bus.mem_we); end
        checks++; if (bus.done !== 4'b0000 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_done: got done=%b err=%b expected 0000 0", bus.done, bus.err); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); end
        checks++; if (dbg_state !== mem_arb_pkg::IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        // mem_ready while idle must do nothing
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A_5A5A;
        tick();
        checks++; if (bus.done !== 4'b0000 || bus.rdata !== 32'h0 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL idle_ready: got done=%b rdata=%h valid=%b expected 0000 00000000 0", bus.done, bus.rdata, bus.mem_valid); end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_single_read();
        bus.req   = 4'b0001;
        bus.we    = 4'b0000;
        bus.addr0 = 32'h0000_0100;
        tick();
        checks++; if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin errors++; $display("FAIL read_grant: got gnt=%b sel=%0d expected 0001 0", bus.gnt, bus.sel); end
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL read_valid: got valid=%b we=%b expected 1 0", bus.mem_valid, bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL read_addr: got %h expected 00000100", bus.mem_addr); end
        tick();
        tick();
        checks++; if (bus.mem_valid !== 1'b1 || bus.gnt !== 4'b0001 || bus.done !== 4'b0000) begin errors++; $display("FAIL read_hold: got valid=%b gnt=%b done=%b expected 1 0001 0000", bus.mem_valid, bus.gnt, bus.done); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL read_done: got %b expected 0001", bus.done); end
        checks++; if (bus.mem_valid !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL read_release: got valid=%b gnt=%b expected 0 0000", bus.mem_valid, bus.gnt); end
        checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", bus.rdata); end
        // req was still high in the done cycle; it must not be granted again
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.done !== 4'b0000 || bus.gnt !== 4'b0000 || dbg_state !== mem_arb_pkg::IDLE) begin errors++; $display("FAIL read_no_regrant: got done=%b gnt=%b state=%0d expected 0000 0000 0", bus.done, bus.gnt, dbg_state); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        apply_reset();
        bus.req       = 4'b1111;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_s = 2'(i % 4);
            exp_g = 4'b0001 << exp_s;
            bus.mem_rdata = 32'hA000_0000 + 32'(i);
            exp_q.push_back(32'hA000_0000 + 32'(i));
            tick();
            checks++; if (bus.gnt !== exp_g || bus.sel !== exp_s || bus.mem_valid !== 1'b1) begin errors++; $display("FAIL fair_grant%0d: got gnt=%b sel=%0d valid=%b expected %b %0d 1", i, bus.gnt, bus.sel, bus.mem_valid, exp_g, exp_s); end
            tick();
            checks++; if (bus.done !== exp_g || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fair_done%0d: got done=%b valid=%b expected %b 0", i, bus.done, bus.mem_valid, exp_g); end
            checks++; if (bus.rdata !== exp_q[0]) begin errors++; $display("FAIL fair_rdata%0d: got %h expected %h", i, bus.rdata, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        bus.req       = 4'b0000;
        bus.mem_ready = 1'b0;
        tick();
        checks++; if (bus.gnt !== 4'b0000 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fair_idle: got gnt=%b valid=%b expected 0000 0", bus.gnt, bus.mem_valid); end
    endtask

    task automatic test_write();
        bus.req    = 4'b0100;
        bus.we     = 4'b0100;
        bus.addr2  = 32'h0000_0200;
        bus.wdata2 = 32'h1234_5678;
        bus.wdata0 = 32'hFFFF_0000;
        tick();
        checks++; if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin errors++; $display("FAIL write_grant: got gnt=%b sel=%0d expected 0100 2", bus.gnt, bus.sel); end
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL write_bus: got we=%b wdata=%h addr=%h expected 1 12345678 00000200", bus.mem_we, bus.mem_wdata, bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (bus.done !== 4'b0100 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL write_done: got done=%b we=%b expected 0100 0", bus.done, bus.mem_we); end
        checks++; if (bus.rdata !== 32'hA000_0004) begin errors++; $display("FAIL write_rdata: got %h expected a0000004", bus.rdata); end
        bus.req = 4'b0000;
        bus.we  = 4'b0000;
        tick();
    endtask

    task automatic test_priority();
        bus.req   = 4'b0010;
        bus.addr1 = 32'h0000_0104;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL prio_setup: got %b expected 0010", bus.gnt); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        tick();
        checks++; if (bus.done !== 4'b0010 || bus.rdata !== 32'h1111_1111) begin errors++; $display("FAIL prio_setup_done: got done=%b rdata=%h expected 0010 11111111", bus.done, bus.rdata); end
        // ptr is now 1: search order 2,3,0,1
        bus.mem_ready = 1'b0;
        bus.req       = 4'b0011;
        bus.addr0     = 32'h0000_0108;
        tick();
        checks++; if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0 || bus.mem_addr !== 32'h0000_0108) begin errors++; $display("FAIL prio_grant: got gnt=%b sel=%0d addr=%h expected 0001 0 00000108", bus.gnt, bus.sel, bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h2222_2222;
        tick();
        checks++; if (bus.done !== 4'b0001 || bus.rdata !== 32'h2222_2222) begin errors++; $display("FAIL prio_done: got done=%b rdata=%h expected 0001 22222222", bus.done, bus.rdata); end
        bus.mem_ready = 1'b0;
        bus.req       = 4'b0010;
        tick();
        checks++; if (bus.gnt !== 4'b0010 || bus.sel !== 2'd1) begin errors++; $display("FAIL prio_next: got gnt=%b sel=%0d expected 0010 1", bus.gnt, bus.sel); end
    endtask

    task automatic test_reset_mid_busy();
        bus.req = 4'b0011;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0000 || bus.mem_valid !== 1'b0 || dbg_state !== mem_arb_pkg::IDLE) begin errors++; $display("FAIL rst_busy_async: got gnt=%b valid=%b state=%0d expected 0000 0 0", bus.gnt, bus.mem_valid, dbg_state); end
        checks++; if (bus.rdata !== 32'h0 || bus.sel !== 2'd0) begin errors++; $display("FAIL rst_busy_regs: got rdata=%h sel=%0d expected 00000000 0", bus.rdata, bus.sel); end
        tick();
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL rst_busy_nodone: got %b expected 0000", bus.done); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin errors++; $display("FAIL rst_busy_regrant: got gnt=%b sel=%0d expected 0001 0", bus.gnt, bus.sel); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h3333_3333;
        tick();
        checks++; if (bus.done !== 4'b0001 || bus.rdata !== 32'h3333_3333) begin errors++; $display("FAIL rst_busy_done: got done=%b rdata=%h expected 0001 33333333", bus.done, bus.rdata); end
        bus.mem_ready = 1'b0;
        bus.req       = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int pulses;
        pulses  = 0;
        bus.req = 4'b1000;
        tick();
        checks++; if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin errors++; $display("FAIL tmo_grant: got gnt=%b sel=%0d expected 1000 3", bus.gnt, bus.sel); end
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done !== 4'b0000) pulses++;
        end
        checks++; if (pulses != 0 || bus.mem_valid !== 1'b1) begin errors++; $display("FAIL tmo_early: got pulses=%0d valid=%b expected 0 1", pulses, bus.mem_valid); end
        tick();
        checks++; if (bus.done !== 4'b1000 || bus.err !== 1'b1) begin errors++; $display("FAIL tmo_abort: got done=%b err=%b expected 1000 1", bus.done, bus.err); end
        checks++; if (bus.rdata !== 32'h3333_3333 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL tmo_rdata: got rdata=%h valid=%b expected 33333333 0", bus.rdata, bus.mem_valid); end
        bus.req = 4'b0100;
        tick();
        checks++; if (bus.gnt !== 4'b0100 || bus.err !== 1'b0) begin errors++; $display("FAIL tmo_next_grant: got gnt=%b err=%b expected 0100 0", bus.gnt, bus.err); end
        for (int i = 0; i < 15; i++) tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        tick();
        checks++; if (bus.done !== 4'b0100 || bus.err !== 1'b0 || bus.rdata !== 32'h5555_5555) begin errors++; $display("FAIL tmo_ready_wins: got done=%b err=%b rdata=%h expected 0100 0 55555555", bus.done, bus.err, bus.rdata); end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.done !== 4'b0000 || bus.err !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL notmo_pulses: got %0d expected 0", pulses); end
        checks++; if (bus.mem_valid !== 1'b1 || dbg_state !== mem_arb_pkg::BUSY || bus.gnt !== 4'b1000) begin errors++; $display("FAIL notmo_busy: got valid=%b state=%0d gnt=%b expected 1 1 1000", bus.mem_valid, dbg_state, bus.gnt); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h4444_4444;
        tick();
        checks++; if (bus.done !== 4'b1000 || bus.err !== 1'b0 || bus.rdata !== 32'h4444_4444) begin errors++; $display("FAIL notmo_done: got done=%b err=%b rdata=%h expected 1000 0 44444444", bus.done, bus.err, bus.rdata); end
`endif
        bus.mem_ready = 1'b0;
        bus.req       = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_write();
        test_priority();
        test_reset_mid_busy();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
